// File: rtl/rib_mem_arbiter.sv
// Arbiter that lets instruction fetch and load/store share one memory port, with data given priority over fetch.
// Latency: a request seen in IDLE drives mem_req_o on the next cycle; the owner's ready and rdata follow mem_ready_i in the same cycle.
// Backpressure: each master holds its req until its ready pulse, and hold_o stalls the pipeline while a data access is pending.
module rib_mem_arbiter #(
    parameter int AddrWidth     = 32,
    parameter int DataWidth     = 32,
    parameter int MaxConsecEx   = 4,
    parameter int TimeoutCycles = 0
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 if_req_i,
    input  logic [AddrWidth-1:0] if_addr_i,
    output logic [DataWidth-1:0] if_rdata_o,
    output logic                 if_ready_o,
    output logic                 if_err_o,
    input  logic                 ex_req_i,
    input  logic                 ex_we_i,
    input  logic [AddrWidth-1:0] ex_addr_i,
    input  logic [DataWidth-1:0] ex_wdata_i,
    output logic [DataWidth-1:0] ex_rdata_o,
    output logic                 ex_ready_o,
    output logic                 ex_err_o,
    output logic                 mem_req_o,
    output logic                 mem_we_o,
    output logic [AddrWidth-1:0] mem_addr_o,
    output logic [DataWidth-1:0] mem_wdata_o,
    input  logic [DataWidth-1:0] mem_rdata_i,
    input  logic                 mem_ready_i,
    output logic                 hold_o,
    output logic                 busy_o
);
    localparam int CW = (MaxConsecEx > 0) ? $clog2(MaxConsecEx + 1) : 1;
    localparam int TW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
    localparam logic [CW-1:0] CNT_MAX   = CW'(MaxConsecEx);
    localparam logic [TW-1:0] TCNT_LAST = TW'((TimeoutCycles > 0) ? TimeoutCycles - 1 : 0);

    typedef enum logic [1:0] {IDLE, GNT_EX, GNT_IF} state_e;

    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q;
    logic [TW-1:0]        tcnt_q;
    logic [AddrWidth-1:0] addr_q;
    logic                 we_q;
    logic [DataWidth-1:0] wdata_q;
    logic                 grant, timeout_hit, done;

    assign grant       = (state_q != IDLE);
    // A slave ready arriving in the final timeout cycle takes precedence over the error.
    assign timeout_hit = (TimeoutCycles != 0) && grant && (tcnt_q == TCNT_LAST) && !mem_ready_i;
    assign done        = grant && (mem_ready_i || timeout_hit);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (ex_req_i && (!if_req_i || (cnt_q < CNT_MAX))) state_d = GNT_EX;
                else if (if_req_i)                                 state_d = GNT_IF;
            end
            GNT_EX, GNT_IF: if (done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q   <= '0;
            tcnt_q  <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
        end else begin
            if (state_q == IDLE && state_d == GNT_EX) begin
                addr_q  <= ex_addr_i;
                we_q    <= ex_we_i;
                wdata_q <= ex_wdata_i;
                if (!if_req_i)               cnt_q <= '0;
                else if (cnt_q != CNT_MAX)   cnt_q <= cnt_q + CW'(1);
            end else if (state_q == IDLE && state_d == GNT_IF) begin
                addr_q  <= if_addr_i;
                we_q    <= 1'b0;
                wdata_q <= '0;
                cnt_q   <= '0;
            end
            if (!grant || done) tcnt_q <= '0;
            else                tcnt_q <= tcnt_q + TW'(1);
        end
    end

    always_comb begin
        if_ready_o = 1'b0;
        if_err_o   = 1'b0;
        if_rdata_o = '0;
        ex_ready_o = 1'b0;
        ex_err_o   = 1'b0;
        ex_rdata_o = '0;
        if (state_q == GNT_IF) begin
            if_ready_o = done;
            if_err_o   = timeout_hit;
            if (mem_ready_i) if_rdata_o = mem_rdata_i;
        end
        if (state_q == GNT_EX) begin
            ex_ready_o = done;
            ex_err_o   = timeout_hit;
            if (mem_ready_i) ex_rdata_o = mem_rdata_i;
        end
    end

    assign mem_req_o   = grant;
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign hold_o      = ex_req_i & ~ex_ready_o;
    assign busy_o      = grant;
endmodule

// File: tb/tb_rib_mem_arbiter.sv
// Directed bench for rib_mem_arbiter: fetch, priority, starvation limit, timeout, reset and address stability.
// Inputs change 1ns after each rising edge, and outputs are sampled 1ns later.
module tb_rib_mem_arbiter;
    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        if_req_i, ex_req_i, ex_we_i, mem_ready_i;
    logic [31:0] if_addr_i, ex_addr_i, ex_wdata_i, mem_rdata_i;
    logic [31:0] if_rdata_o, ex_rdata_o, mem_addr_o, mem_wdata_o;
    logic        if_ready_o, if_err_o, ex_ready_o, ex_err_o;
    logic        mem_req_o, mem_we_o, hold_o, busy_o;

    int n_checks = 0;
    int n_fail   = 0;

    rib_mem_arbiter #(
        .AddrWidth(32), .DataWidth(32), .MaxConsecEx(4), .TimeoutCycles(8)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o),
        .if_ready_o(if_ready_o), .if_err_o(if_err_o),
        .ex_req_i(ex_req_i), .ex_we_i(ex_we_i), .ex_addr_i(ex_addr_i),
        .ex_wdata_i(ex_wdata_i), .ex_rdata_o(ex_rdata_o),
        .ex_ready_o(ex_ready_o), .ex_err_o(ex_err_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
        .mem_ready_i(mem_ready_i), .hold_o(hold_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    int exp_ex[6] = '{1, 1, 1, 1, 0, 1};
    int owner[$];

    initial begin
        rst_ni = 1'b0;
        if_req_i = 0; ex_req_i = 0; ex_we_i = 0; mem_ready_i = 0;
        if_addr_i = 0; ex_addr_i = 0; ex_wdata_i = 0; mem_rdata_i = 0;
        #2;
        chk("rst_mem_req", mem_req_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_mem_addr", mem_addr_o, 0);
        chk("rst_if_ready", if_ready_o, 0);
        chk("rst_ex_ready", ex_ready_o, 0);
        chk("rst_hold", hold_o, 0);
        #20 rst_ni = 1'b1;

        // Single fetch with the slave answering two cycles after mem_req_o
        tick(); if_req_i = 1; if_addr_i = 32'h100;
        #1 chk("f_idle_req", mem_req_o, 0);
        tick(); #1;
        chk("f_mem_req", mem_req_o, 1);
        chk("f_mem_addr", mem_addr_o, 32'h100);
        chk("f_mem_we", mem_we_o, 0);
        tick(); #1 chk("f_wait_ready", if_ready_o, 0);
        tick(); mem_ready_i = 1; mem_rdata_i = 32'hDEADBEEF;
        #1;
        chk("f_ready", if_ready_o, 1);
        chk("f_rdata", if_rdata_o, 32'hDEADBEEF);
        chk("f_err", if_err_o, 0);
        chk("f_ex_ready", ex_ready_o, 0);
        chk("f_ex_rdata", ex_rdata_o, 0);
        tick(); if_req_i = 0; mem_ready_i = 0;
        #1;
        chk("f_busy_after", busy_o, 0);
        chk("f_ready_once", if_ready_o, 0);
        chk("f_rdata_idle", if_rdata_o, 0);

        // Simultaneous ex write and fetch; ex address changed during the grant
        tick(); ex_req_i = 1; ex_we_i = 1; ex_addr_i = 32'h2000; ex_wdata_i = 32'h55;
        if_req_i = 1; if_addr_i = 32'h104;
        #1 chk("s_hold", hold_o, 1);
        tick(); ex_addr_i = 32'h3000;
        #1;
        chk("s_mem_we", mem_we_o, 1);
        chk("s_mem_wdata", mem_wdata_o, 32'h55);
        chk("s_mem_addr", mem_addr_o, 32'h2000);
        tick(); #1 chk("s_addr_stable", mem_addr_o, 32'h2000);
        tick(); mem_ready_i = 1; mem_rdata_i = 32'h12;
        #1;
        chk("s_ex_ready", ex_ready_o, 1);
        chk("s_ex_rdata", ex_rdata_o, 32'h12);
        chk("s_hold_done", hold_o, 0);
        chk("s_if_ready", if_ready_o, 0);
        chk("s_addr_done", mem_addr_o, 32'h2000);
        tick(); ex_req_i = 0; ex_we_i = 0; mem_ready_i = 0;
        #1;
        chk("s_hold_low", hold_o, 0);
        chk("s_busy_idle", busy_o, 0);
        tick(); #1;
        chk("s_f_addr", mem_addr_o, 32'h104);
        chk("s_f_we", mem_we_o, 0);
        chk("s_f_wdata", mem_wdata_o, 0);
        tick(); mem_ready_i = 1; mem_rdata_i = 32'hCAFE;
        #1;
        chk("s_f_ready", if_ready_o, 1);
        chk("s_f_rdata", if_rdata_o, 32'hCAFE);
        tick(); if_req_i = 0; mem_ready_i = 0;

        // Starvation limit: both requests held with an always-ready slave
        tick(); ex_req_i = 1; ex_we_i = 0; ex_addr_i = 32'h2000; if_req_i = 1; mem_ready_i = 1;
        for (int i = 0; i < 12; i++) begin
            tick(); #1;
            if (ex_ready_o) owner.push_back(1);
            if (if_ready_o) owner.push_back(0);
        end
        ex_req_i = 0; if_req_i = 0; mem_ready_i = 0;
        chk("st_count", owner.size(), 6);
        for (int i = 0; i < 6; i++)
            chk($sformatf("st_owner%0d", i), (i < owner.size()) ? owner[i] : -1, exp_ex[i]);

        // Timeout: the slave never answers, and a late ready is ignored
        tick(); ex_req_i = 1; ex_addr_i = 32'h40; mem_rdata_i = 32'hFFFF;
        for (int k = 1; k <= 8; k++) begin
            tick(); #1;
            if (k < 8) chk($sformatf("to_wait%0d", k), ex_ready_o, 0);
        end
        chk("to_ready", ex_ready_o, 1);
        chk("to_err", ex_err_o, 1);
        chk("to_rdata", ex_rdata_o, 0);
        chk("to_if_err", if_err_o, 0);
        tick(); ex_req_i = 0; mem_ready_i = 1;
        #1;
        chk("to_busy", busy_o, 0);
        chk("to_late_ready", ex_ready_o, 0);
        chk("to_late_if", if_ready_o, 0);
        tick(); mem_ready_i = 0;

        // A slave ready in the final timeout cycle completes normally
        tick(); ex_req_i = 1; ex_addr_i = 32'h44;
        for (int k = 1; k < 8; k++) begin
            tick();
        end
        tick(); mem_ready_i = 1; mem_rdata_i = 32'hABCD;
        #1;
        chk("tie_ready", ex_ready_o, 1);
        chk("tie_err", ex_err_o, 0);
        chk("tie_rdata", ex_rdata_o, 32'hABCD);
        tick(); ex_req_i = 0; mem_ready_i = 0;

        // Reset in the middle of an ex grant
        tick(); ex_req_i = 1; ex_addr_i = 32'h500;
        tick(); #1 chk("r_mem_req", mem_req_o, 1);
        #1 rst_ni = 0;
        #1;
        chk("r_mem_req_async", mem_req_o, 0);
        chk("r_busy_async", busy_o, 0);
        chk("r_no_ready", ex_ready_o, 0);
        tick(); mem_ready_i = 1;
        #1 chk("r_no_ready2", ex_ready_o, 0);
        #1 rst_ni = 1; mem_ready_i = 0; ex_addr_i = 32'h600;
        tick(); #1;
        chk("r_regrant", mem_req_o, 1);
        chk("r_regrant_addr", mem_addr_o, 32'h600);
        tick(); mem_ready_i = 1; mem_rdata_i = 32'h77;
        #1;
        chk("r_ready", ex_ready_o, 1);
        chk("r_rdata", ex_rdata_o, 32'h77);
        tick(); ex_req_i = 0; mem_ready_i = 0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
